// File: rtl/winograd_tile_output_serializer.sv
// Winograd output tile serializer: captures one MxM accumulator tile, then shifts, clamps
// and streams it row-major as unsigned pixels under valid/ready flow control.
module winograd_tile_output_serializer #(
  parameter int unsigned KERNEL_SIZE       = 3,
  parameter int unsigned INPUT_TILE_SIZE   = 4,
  parameter int unsigned INPUT_DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH         = KERNEL_DATA_WIDTH + INPUT_DATA_WIDTH + 13,
  parameter int unsigned OUT_DATA_WIDTH    = 8,
  parameter int unsigned SHIFT             = 0,
  localparam int unsigned M                = INPUT_TILE_SIZE - KERNEL_SIZE + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [M*M*ACC_WIDTH-1:0]     i_tile_data,
  input  logic                         i_tile_valid,
  output logic                         o_tile_ready,
  output logic [OUT_DATA_WIDTH-1:0]    o_pixel_data,
  output logic                         o_pixel_data_valid,
  input  logic                         i_pixel_ready,
  output logic                         o_tile_last,
  output logic                         o_sat_flag
);

  localparam int unsigned NumElem = M * M;
  localparam int unsigned IdxW    = (NumElem > 1) ? $clog2(NumElem) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumElem - 1);
  localparam logic signed [ACC_WIDTH-1:0] MaxOut = ACC_WIDTH'((1 << OUT_DATA_WIDTH) - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                         state_q, state_d;
  logic [IdxW-1:0]                idx_q, idx_d;
  logic [NumElem*ACC_WIDTH-1:0]   tile_q, tile_d;
  logic [OUT_DATA_WIDTH-1:0]      pix_q, pix_d;
  logic                           last_q, last_d;
  logic                           clamp_q, clamp_d;  // clamp status of the pixel on the output
  logic                           sat_q, sat_d;

  logic                           tile_ready;
  logic                           accept;
  logic                           pix_xfer;
  logic                           load_en;
  logic [IdxW-1:0]                load_idx;
  logic [NumElem*ACC_WIDTH-1:0]   load_src;
  logic signed [ACC_WIDTH-1:0]    elem;
  logic signed [ACC_WIDTH-1:0]    shifted;
  logic [OUT_DATA_WIDTH-1:0]      conv_pix;
  logic                           conv_clamp;

  // Handshake decode; a new tile may only enter as the last pixel of the old one leaves.
  always_comb begin
    tile_ready = 1'b1;
    if (state_q == StSend) begin
      tile_ready = (idx_q == LastIdx) & i_pixel_ready;
    end
    accept   = i_tile_valid & tile_ready;
    pix_xfer = (state_q == StSend) & i_pixel_ready;
    load_en  = accept | (pix_xfer & (idx_q != LastIdx));
  end

  // Select the element about to be loaded and convert it (shift, then clamp to unsigned range).
  always_comb begin
    load_idx = accept ? '0 : idx_q + IdxW'(1);
    load_src = accept ? i_tile_data : tile_q;
    elem     = '0;
    for (int unsigned e = 0; e < NumElem; e++) begin
      if (load_idx == IdxW'(e)) begin
        elem = load_src[e*ACC_WIDTH +: ACC_WIDTH];
      end
    end
    shifted    = elem >>> SHIFT;
    conv_pix   = shifted[OUT_DATA_WIDTH-1:0];
    conv_clamp = 1'b0;
    if (shifted < 0) begin
      conv_pix   = '0;
      conv_clamp = 1'b1;
    end else if (shifted > MaxOut) begin
      conv_pix   = '1;
      conv_clamp = 1'b1;
    end
  end

  // Next-state: load next element, restart on a chained tile, or fall back to idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tile_d  = tile_q;
    pix_d   = pix_q;
    last_d  = last_q;
    clamp_d = clamp_q;
    sat_d   = sat_q;
    if (pix_xfer) begin
      sat_d = sat_q | clamp_q;
    end
    if (load_en) begin
      state_d = StSend;
      idx_d   = load_idx;
      pix_d   = conv_pix;
      clamp_d = conv_clamp;
      last_d  = (load_idx == LastIdx);
      if (accept) begin
        tile_d = i_tile_data;
      end
    end else if (pix_xfer) begin
      state_d = StIdle;
      idx_d   = '0;
      last_d  = 1'b0;
      clamp_d = 1'b0;
    end
  end

  // State register with synchronous reset that also drops any partially sent tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tile_q  <= '0;
      pix_q   <= '0;
      last_q  <= 1'b0;
      clamp_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tile_q  <= tile_d;
      pix_q   <= pix_d;
      last_q  <= last_d;
      clamp_q <= clamp_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs: everything registered except the ready path, which looks at i_pixel_ready.
  always_comb begin
    o_tile_ready       = tile_ready;
    o_pixel_data       = pix_q;
    o_pixel_data_valid = (state_q == StSend);
    o_tile_last        = last_q;
    o_sat_flag         = sat_q;
  end

endmodule

// File: doc/winograd_tile_output_serializer.md
Name: winograd_tile_output_serializer

Overview:
- Output-side counterpart of the pixel-stream input interface.
- Accepts one packed Winograd output tile (M×M signed accumulator results, M = INPUT_TILE_SIZE − KERNEL_SIZE + 1) per handshake.
- Scales, clamps and serializes the tile into an 8-bit pixel stream, row-major, with valid/ready flow control, so results can leave the convolution core in the same format the core consumes.

Parameters:
- KERNEL_SIZE, 3, kernel edge length
- INPUT_TILE_SIZE, 4, input tile edge length; M = INPUT_TILE_SIZE − KERNEL_SIZE + 1 (localparam, 2 by default)
- INPUT_DATA_WIDTH, 8, input pixel width
- KERNEL_DATA_WIDTH, 8, kernel coefficient width
- ACC_WIDTH, KERNEL_DATA_WIDTH + INPUT_DATA_WIDTH + 13, signed width of one tile element (29 by default)
- OUT_DATA_WIDTH, 8, output pixel width
- SHIFT, 0, arithmetic right shift applied to each element before clamping

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_tile_data  in  M*M*ACC_WIDTH  packed signed tile; element e = r*M + c occupies bits [e*ACC_WIDTH +: ACC_WIDTH]
- i_tile_valid  in  1  i_tile_data is valid
- o_tile_ready  out  1  serializer can accept a tile this cycle
- o_pixel_data  out  OUT_DATA_WIDTH  clamped unsigned output pixel
- o_pixel_data_valid  out  1  o_pixel_data valid
- i_pixel_ready  in  1  downstream accepts the pixel this cycle
- o_tile_last  out  1  current pixel is element M*M−1 of its tile
- o_sat_flag  out  1  sticky: at least one emitted pixel was clamped

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-tile):
  - o_pixel_data = 0, o_pixel_data_valid = 0, o_tile_last = 0, o_sat_flag = 0.
  - FSM goes to IDLE, element counter = 0, capture register cleared.
  - A partially sent tile is discarded.
- FSM states:
  - IDLE: o_tile_ready = 1.
  - SEND: o_tile_ready = 1 only when (idx == M*M−1 AND i_pixel_ready), i.e. the last pixel transfers this cycle; otherwise 0. This ready path is combinational from i_pixel_ready.
- Tile accept (i_tile_valid & o_tile_ready):
  - Latch i_tile_data into the capture register.
  - idx = 0; next cycle o_pixel_data_valid = 1 with element 0.
  - Latency from accept edge to first valid pixel: 1 cycle.
- Pixel transfer (o_pixel_data_valid & i_pixel_ready):
  - If idx < M*M−1: idx increments and o_pixel_data loads the next element.
  - If idx == M*M−1 and a new tile is accepted in the same cycle: stay in SEND with idx = 0 and element 0 of the new tile. No bubble between tiles.
  - If idx == M*M−1 and no new tile: go to IDLE, o_pixel_data_valid = 0.
- Backpressure: while o_pixel_data_valid & !i_pixel_ready, o_pixel_data, o_tile_last and idx hold.
- o_tile_last = o_pixel_data_valid & (idx == M*M−1); registered with the data.
- Element conversion (computed when the element is loaded into the output register):
  - s = element >>> SHIFT (sign-preserving).
  - If s < 0: out = 0 and clamp event.
  - Else if s > 2^OUT_DATA_WIDTH − 1: out = 2^OUT_DATA_WIDTH − 1 and clamp event.
  - Else out = s[OUT_DATA_WIDTH−1:0].
- o_sat_flag sets on the cycle a clamped pixel transfers (valid & ready) and stays set until reset.
- i_tile_valid while o_tile_ready = 0 is ignored; the upstream must hold it.

Test Plan:
- Reset, then tile elements {e0=1, e1=2, e2=3, e3=4} with i_pixel_ready = 1 -> pixels 1, 2, 3, 4 on 4 consecutive cycles starting 1 cycle after accept; o_tile_last high only with 4; o_sat_flag stays 0.
- Tile {−5, 300, 255, 0} -> pixels 0, 255, 255, 0; o_sat_flag rises after pixel 0 transfers and remains 1 after the tile.
- SHIFT = 2 build, tile {40, 1023, −4, 7} -> pixels 10, 255, 0, 1.
- Tile {1, 2, 3, 4}, i_pixel_ready low for 3 cycles while element 1 is presented -> o_pixel_data holds 2 with valid high for those cycles; o_tile_ready stays 0; then 3, 4 follow.
- Two tiles {1, 2, 3, 4} and {5, 6, 7, 8}, i_tile_valid held high, i_pixel_ready = 1 -> 8 pixels 1..8 on 8 consecutive cycles; second tile accepted in the cycle 4 transfers; o_tile_last on 4 and 8.
- Reset asserted for 1 cycle while pixel 2 of tile {1, 2, 3, 4} is presented -> next cycle valid = 0, o_tile_ready = 1; a following tile {9, 9, 9, 9} emits 9, 9, 9, 9 cleanly.
